shift_arbiter: RTL and testbench

Shares one combinational barrel shifter (`shifter_top`) between two requesters, e.g. the integer pipe (port 0) and a multi-cycle helper such as a CSR/bit-manipulation sequencer (port 1). Each requester uses a valid/ready handshake. The arbiter grants at most one request per cycle and registers the shifter result into a single-entry response slot, tagged with the winner's ID. Malformed shift encodings are flagged rather than silently executed.

---
 rtl/shift_arbiter.sv | 159 +++++++++++++++
 tb/tb_shift_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two requesters share one combinational barrel shifter and write into a single-entry response slot.
// Build option: define SHIFT_ARB_RR_EN for a round-robin tie-break; the default build uses fixed priority to requester 0.

module shifter_top (
    input  logic [31:0] operand_i,
    input  logic [4:0]  shamt_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic [31:0] result_o,
    output logic        illegal_o
);

    logic        isSll;
    logic        isSrl;
    logic        isSra;
    logic        fill;
    logic [31:0] preShift;
    logic [31:0] postShift;

    function automatic logic [31:0] reverseBits(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Left shifts reuse the right-shift path by mirroring the operand in and the result out.
    always_comb begin
        isSll     = (funct3_i == 3'b001) && (funct7_i == 7'b0000000);
        isSrl     = (funct3_i == 3'b101) && (funct7_i == 7'b0000000);
        isSra     = (funct3_i == 3'b101) && (funct7_i == 7'b0100000);
        illegal_o = !(isSll || isSrl || isSra);
        fill      = isSra & operand_i[31];
        preShift  = isSll ? reverseBits(operand_i) : operand_i;
        postShift = 32'({{32{fill}}, preShift} >> shamt_i);
        result_o  = illegal_o ? 32'h0 : (isSll ? reverseBits(postShift) : postShift);
    end

endmodule

module shift_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in,
    input  logic [4:0]      req0_shamt,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in,
    input  logic [4:0]      req1_shamt,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_id,
    output logic            rsp_err
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            id_q, id_d;
    logic            err_q, err_d;

    logic            grant0;
    logic            grant1;
    logic            slotFree;
    logic            accept;
    logic [XLEN-1:0] shOperand;
    logic [4:0]      shShamt;
    logic [2:0]      shFunct3;
    logic [6:0]      shFunct7;
    logic [XLEN-1:0] shResult;
    logic            shIllegal;

`ifdef SHIFT_ARB_RR_EN
    logic last_q, last_d;

    assign grant0 = req0_valid & (!req1_valid | last_q);
    assign grant1 = req1_valid & (!req0_valid | !last_q);
    assign last_d = accept ? grant1 : last_q;

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & !req0_valid;
`endif

    assign slotFree   = (state_q == EMPTY) | rsp_ready;
    assign req0_ready = grant0 & slotFree;
    assign req1_ready = grant1 & slotFree;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign shOperand = grant1 ? req1_in     : req0_in;
    assign shShamt   = grant1 ? req1_shamt  : req0_shamt;
    assign shFunct3  = grant1 ? req1_funct3 : req0_funct3;
    assign shFunct7  = grant1 ? req1_funct7 : req0_funct7;

    shifter_top u_shifter (
        .operand_i (shOperand),
        .shamt_i   (shShamt),
        .funct3_i  (shFunct3),
        .funct7_i  (shFunct7),
        .result_o  (shResult),
        .illegal_o (shIllegal)
    );

    // An accept overwrites the slot even while it drains, which keeps one result per cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (accept) begin
            state_d = FULL;
            data_d  = shResult;
            id_d    = grant1;
            err_d   = shIllegal;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized scoreboard bench for shift_arbiter: a transaction-level model predicts grants and results,
// and a separate monitor compares every consumed response and checks output stability under backpressure.

module tb_shift_arbiter;

    typedef struct packed {
        logic        err;
        logic        id;
        logic [31:0] data;
    } rsp_t;

`ifdef SHIFT_ARB_RR_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_in;
    logic [4:0]  req0_shamt;
    logic [2:0]  req0_funct3;
    logic [6:0]  req0_funct7;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_in;
    logic [4:0]  req1_shamt;
    logic [2:0]  req1_funct3;
    logic [6:0]  req1_funct7;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_err;

    rsp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    bit   modelFull = 1'b0;
    bit   modelLast = 1'b1;

    always #5 clk = ~clk;

    shift_arbiter #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_in     (req0_in),
        .req0_shamt  (req0_shamt),
        .req0_funct3 (req0_funct3),
        .req0_funct7 (req0_funct7),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_in     (req1_in),
        .req1_shamt  (req1_shamt),
        .req1_funct3 (req1_funct3),
        .req1_funct7 (req1_funct7),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // What an RV32 shift instruction should produce, straight from the encoding rules.
    function automatic rsp_t refShift(input logic [31:0] a, input logic [4:0] sh,
                                      input logic [2:0] f3, input logic [6:0] f7, input logic id);
        rsp_t               r;
        logic signed [31:0] s;
        s      = a;
        r.id   = id;
        r.err  = 1'b1;
        r.data = 32'h0;
        if (f3 == 3'b001 && f7 == 7'h00) begin
            r.err  = 1'b0;
            r.data = a << sh;
        end else if (f3 == 3'b101 && f7 == 7'h00) begin
            r.err  = 1'b0;
            r.data = a >> sh;
        end else if (f3 == 3'b101 && f7 == 7'h20) begin
            r.err  = 1'b0;
            r.data = s >>> sh;
        end
        return r;
    endfunction

    // Drives one cycle of requests, checks readies against the model and predicts the accepted response.
    task automatic applyStimulus(input bit v0, input bit v1, input bit rdy,
                                 input logic [31:0] a0, input logic [4:0] s0, input logic [2:0] f30, input logic [6:0] f70,
                                 input logic [31:0] a1, input logic [4:0] s1, input logic [2:0] f31, input logic [6:0] f71);
        bit pick0, pick1, free;
        @(negedge clk);
        req0_valid  = v0;  req0_in = a0; req0_shamt = s0; req0_funct3 = f30; req0_funct7 = f70;
        req1_valid  = v1;  req1_in = a1; req1_shamt = s1; req1_funct3 = f31; req1_funct7 = f71;
        rsp_ready   = rdy;
        #1;
        pick0 = v0 && (!v1 || !RoundRobin || modelLast);
        pick1 = v1 && !pick0;
        free  = !modelFull || rdy;
        checkOutput("req0_ready", 64'(req0_ready), 64'(pick0 && free));
        checkOutput("req1_ready", 64'(req1_ready), 64'(pick1 && free));
        if ((pick0 || pick1) && free) begin
            expQ.push_back(pick1 ? refShift(a1, s1, f31, f71, 1'b1) : refShift(a0, s0, f30, f70, 1'b0));
            modelFull = 1'b1;
            modelLast = pick1;
        end else if (rdy) begin
            modelFull = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is consumed and checks held outputs.
    initial begin
        rsp_t prev;
        rsp_t cur;
        rsp_t expected;
        bit   holdPending;
        holdPending = 1'b0;
        prev        = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                holdPending = 1'b0;
            end else begin
                cur = {rsp_err, rsp_id, rsp_data};
                if (holdPending) begin
                    checkOutput("rsp_hold", {29'h0, rsp_valid, cur}, {29'h0, 1'b1, prev});
                end
                if (rsp_valid && rsp_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL rsp_unexpected: got 0x%0h, expected no response", cur);
                    end else begin
                        expected = expQ.pop_front();
                        checkOutput("rsp", 64'(cur), 64'(expected));
                    end
                end
                holdPending = rsp_valid && !rsp_ready;
                prev        = cur;
            end
        end
    end

    initial begin
        logic [31:0] a0, a1;
        logic [4:0]  s0, s1;
        logic [2:0]  f30, f31;
        logic [6:0]  f70, f71;

        req0_valid = 0; req0_in = 0; req0_shamt = 0; req0_funct3 = 0; req0_funct7 = 0;
        req1_valid = 0; req1_in = 0; req1_shamt = 0; req1_funct3 = 0; req1_funct7 = 0;
        rsp_ready  = 0;
        rst        = 1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_data", 64'(rsp_data), 64'h0);
        checkOutput("reset_id", 64'(rsp_id), 64'h0);
        checkOutput("reset_err", 64'(rsp_err), 64'h0);
        rst = 0;

        // Single SLL, then SRA and SRL of the same operand.
        applyStimulus(1, 0, 1, 32'h1, 5'd31, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        applyStimulus(0, 1, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'h8000_0000, 5'd4, 3'b101, 7'h20);
        applyStimulus(0, 1, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'h8000_0000, 5'd4, 3'b101, 7'h00);

        // Contention for four cycles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 32'h0000_00F0 + i, 5'(i), 3'b001, 7'h00, 32'hF000_0000 + i, 5'(i + 1), 3'b101, 7'h20);
        end

        // Illegal encodings are consumed and still move the priority pointer.
        applyStimulus(0, 1, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'h1234_5678, 5'd3, 3'b001, 7'h20);
        applyStimulus(1, 0, 1, 32'hFFFF_FFFF, 5'd7, 3'b000, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        applyStimulus(1, 1, 1, 32'h0000_0003, 5'd1, 3'b001, 7'h00, 32'h0000_0300, 5'd8, 3'b101, 7'h00);

        // Backpressure: hold the slot for three cycles, then drain and accept together.
        applyStimulus(1, 0, 0, 32'hA5A5_0001, 5'd2, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 32'h1111_1111, 5'd1, 3'b001, 7'h00, 32'h2222_2222, 5'd1, 3'b101, 7'h00);
        end
        applyStimulus(0, 1, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'hC000_0000, 5'd30, 3'b101, 7'h20);
        #1;
        checkOutput("drain_accept_valid", 64'(rsp_valid), 64'h1);

        // Reset while FULL discards the pending result.
        applyStimulus(0, 0, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        applyStimulus(1, 0, 0, 32'hDEAD_BEEF, 5'd0, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        applyStimulus(0, 0, 0, 32'h0, 5'd0, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        #2;
        checkOutput("prereset_data", {31'h0, rsp_valid, rsp_data}, {31'h0, 1'b1, 32'hDEAD_BEEF});
        rst = 1;
        #1;
        checkOutput("midreset_valid", 64'(rsp_valid), 64'h0);
        checkOutput("midreset_data", 64'(rsp_data), 64'h0);
        checkOutput("midreset_id_err", {62'h0, rsp_id, rsp_err}, 64'h0);
        expQ.delete();
        modelFull = 1'b0;
        modelLast = 1'b1;
        @(negedge clk);
        #3;
        rst = 0;
        applyStimulus(1, 1, 1, 32'h0000_0010, 5'd4, 3'b001, 7'h00, 32'h0000_0100, 5'd4, 3'b101, 7'h00);

        // Randomized traffic with occasional malformed encodings.
        for (int i = 0; i < 400; i++) begin
            a0  = $urandom;
            a1  = $urandom;
            s0  = 5'($urandom);
            s1  = 5'($urandom);
            f30 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101);
            f31 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101);
            f70 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20);
            f71 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          a0, s0, f30, f70, a1, s1, f31, f71);
        end

        repeat (4) applyStimulus(0, 0, 1, 32'h0, 5'd0, 3'b001, 7'h00, 32'h0, 5'd0, 3'b001, 7'h00);
        #3;
        checkOutput("queue_empty", 64'(expQ.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
